// File: rtl/tick_pwm_if.sv
// Config port for tick_pwm: a new period/duty pair offered with a valid/ready handshake.
interface tick_pwm_if #(
  parameter int WIDTH = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/tick_pwm.sv
// Tick-resolution PWM with frame-start strobe; outputs update one clock after the sampled tick.
// Config is double-buffered: one shadow slot, ready drops while a config waits for the next wrap.
module tick_pwm #(
  parameter int WIDTH        = 4,
  parameter int RESET_PERIOD = 5,
  parameter int RESET_DUTY   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  tick_pwm_if.slave        cfg,
  output logic             pwm,
  output logic             frame_start,
  output logic [WIDTH-1:0] count
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       PENDING = 1'b1;
  localparam logic [WIDTH-1:0] RST_P   = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] RST_D   = WIDTH'(RESET_DUTY);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [0:0]       state_q, state_d;
  logic             pwm_q, pwm_d;
  logic             fs_q, fs_d;

  logic             wrap;
  logic             accept;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH-1:0] duty_next_frame;

  assign wrap    = tick && (count_q == period_act_q);
  assign accept  = cfg.cfg_valid && (state_q == IDLE);
  assign cnt_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  // A pending config governs the frame that starts at this wrap, including its first pwm level.
  assign duty_next_frame = (state_q == PENDING) ? duty_sh_q : duty_act_q;

  always_comb begin
    count_d      = count_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    period_sh_d  = period_sh_q;
    duty_sh_d    = duty_sh_q;
    state_d      = state_q;
    pwm_d        = pwm_q;
    fs_d         = 1'b0;

    if (wrap) begin
      count_d = '0;
      fs_d    = 1'b1;
      pwm_d   = (duty_next_frame != '0);
      if (state_q == PENDING) begin
        period_act_d = period_sh_q;
        duty_act_d   = duty_sh_q;
        state_d      = IDLE;
      end
    end else if (tick) begin
      count_d = cnt_inc[WIDTH-1:0];
      pwm_d   = (cnt_inc < {1'b0, duty_act_q});
    end

    // accept only fires in IDLE, so it never collides with the PENDING->IDLE apply above
    if (accept) begin
      period_sh_d = cfg.cfg_period;
      duty_sh_d   = cfg.cfg_duty;
      state_d     = PENDING;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= RST_P;
      period_act_q <= RST_P;
      duty_act_q   <= RST_D;
      period_sh_q  <= '0;
      duty_sh_q    <= '0;
      state_q      <= IDLE;
      pwm_q        <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      count_q      <= count_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      period_sh_q  <= period_sh_d;
      duty_sh_q    <= duty_sh_d;
      state_q      <= state_d;
      pwm_q        <= pwm_d;
      fs_q         <= fs_d;
    end
  end

  assign cfg.cfg_ready = (state_q == IDLE);
  assign pwm           = pwm_q;
  assign frame_start   = fs_q;
  assign count         = count_q;

endmodule

// File: tb/tb_tick_pwm.sv
// Directed + random bench for tick_pwm: a reference model predicts each cycle's outputs into a scoreboard queue.
module tb_tick_pwm;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       pwm;
  logic       frame_start;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pwm;
    logic       fs;
    logic [3:0] cnt;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [3:0] m_count, m_pact, m_dact, m_psh, m_dsh;
  logic       m_pend, m_pwm, m_fs;

  tick_pwm_if #(.WIDTH(4)) cfg_if ();

  tick_pwm #(.WIDTH(4), .RESET_PERIOD(5), .RESET_DUTY(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .cfg         (cfg_if),
    .pwm         (pwm),
    .frame_start (frame_start),
    .count       (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic r, input logic t, input logic v,
                       input logic [3:0] p, input logic [3:0] d);
    logic accept;
    logic [4:0] nxt;
    if (r) begin
      m_count = 4'd5; m_pact = 4'd5; m_dact = 4'd2;
      m_pend = 1'b0; m_pwm = 1'b0; m_fs = 1'b0;
      return;
    end
    accept = v && !m_pend;
    m_fs = 1'b0;
    if (t && m_count == m_pact) begin
      m_count = 4'd0;
      m_fs = 1'b1;
      if (m_pend) begin
        m_pact = m_psh; m_dact = m_dsh; m_pend = 1'b0;
      end
      m_pwm = (m_dact > 4'd0);
    end else if (t) begin
      nxt = {1'b0, m_count} + 5'd1;
      m_count = nxt[3:0];
      m_pwm = (nxt < {1'b0, m_dact});
    end
    if (accept) begin
      m_psh = p; m_dsh = d; m_pend = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic t, input logic v,
                      input logic [3:0] p, input logic [3:0] d);
    exp_t e, got;
    @(negedge clock);
    reset = r; tick = t;
    cfg_if.cfg_valid = v; cfg_if.cfg_period = p; cfg_if.cfg_duty = d;
    model(r, t, v, p, d);
    e.pwm = m_pwm; e.fs = m_fs; e.cnt = m_count; e.rdy = !m_pend;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got.pwm = pwm; got.fs = frame_start; got.cnt = count; got.rdy = cfg_if.cfg_ready;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL cycle t=%0t: observed pwm=%b fs=%b cnt=%0d rdy=%b expected pwm=%b fs=%b cnt=%0d rdy=%b",
               $time, got.pwm, got.fs, got.cnt, got.rdy, e.pwm, e.fs, e.cnt, e.rdy);
      end
    end
  endtask

  task automatic tick3();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_duty = '0;

    // 1: reset, then a tick every third clock through one full frame and the next wrap
    step(1, 0, 0, 0, 0);
    chk("rst_count", count, 4'd5);
    chk("rst_pwm", {3'b0, pwm}, 4'd0);
    chk("rst_fs", {3'b0, frame_start}, 4'd0);
    chk("rst_ready", {3'b0, cfg_if.cfg_ready}, 4'd1);
    step(0, 1, 0, 0, 0);
    chk("first_wrap_fs", {3'b0, frame_start}, 4'd1);
    chk("first_wrap_cnt", count, 4'd0);
    chk("first_wrap_pwm", {3'b0, pwm}, 4'd1);
    step(0, 0, 0, 0, 0);
    chk("fs_one_clock", {3'b0, frame_start}, 4'd0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("cnt1_pwm", {3'b0, pwm}, 4'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("cnt2_pwm", {3'b0, pwm}, 4'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick3();
    chk("cnt5", count, 4'd5);
    step(0, 1, 0, 0, 0);
    chk("second_wrap_fs", {3'b0, frame_start}, 4'd1);
    chk("second_wrap_cnt", count, 4'd0);

    // 2: idle hold at count=3
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    chk("hold_cnt", count, 4'd3);
    chk("hold_pwm", {3'b0, pwm}, 4'd0);
    chk("hold_fs", {3'b0, frame_start}, 4'd0);

    // 3: offer P=3 D=1 at count=2; second offer while busy is dropped
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("at_cnt2", count, 4'd2);
    step(0, 0, 1, 4'd3, 4'd1);
    chk("busy_ready", {3'b0, cfg_if.cfg_ready}, 4'd0);
    step(0, 0, 1, 4'd7, 4'd7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("old_frame_full", count, 4'd5);
    step(0, 1, 0, 0, 0);
    chk("new_frame_pwm0", {3'b0, pwm}, 4'd1);
    chk("ready_after_wrap", {3'b0, cfg_if.cfg_ready}, 4'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("short_frame_end", count, 4'd3);
    step(0, 1, 0, 0, 0);
    chk("short_frame_wrap", {3'b0, frame_start}, 4'd1);

    // 4: boundary configs, each loaded then run for two frames
    step(0, 0, 1, 4'd3, 4'd0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk("d0_pwm", {3'b0, pwm}, 4'd0);
    step(0, 0, 1, 4'd3, 4'd9);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk("dbig_pwm", {3'b0, pwm}, 4'd1);
    step(0, 0, 1, 4'd0, 4'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    chk("p0_fs", {3'b0, frame_start}, 4'd1);
    chk("p0_pwm", {3'b0, pwm}, 4'd1);

    // 5: accept coincides with a wrap tick; applied one wrap later
    step(0, 1, 1, 4'd2, 4'd1);
    chk("coinc_old_cnt", count, 4'd0);
    chk("coinc_pending", {3'b0, cfg_if.cfg_ready}, 4'd0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("coinc_new_p", count, 4'd1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("coinc_new_wrap", {3'b0, frame_start}, 4'd1);

    // 6: reset mid-frame with a pending config and an offer during reset
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 4'd9, 4'd4);
    step(1, 1, 1, 4'd7, 4'd7);
    chk("mid_rst_cnt", count, 4'd5);
    chk("mid_rst_pwm", {3'b0, pwm}, 4'd0);
    chk("mid_rst_fs", {3'b0, frame_start}, 4'd0);
    chk("mid_rst_ready", {3'b0, cfg_if.cfg_ready}, 4'd1);
    step(0, 1, 0, 0, 0);
    chk("post_rst_wrap", {3'b0, frame_start}, 4'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("post_rst_default_p", count, 4'd5);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
